// File: rtl/ram_burst_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : ram_burst_ctrl_if
// Purpose  : Client-side handshake bundle for ram_burst_ctrl: burst request,
//            write-beat stream and read-beat stream.
// Revision : 1.0 - initial release
// ============================================================================
interface ram_burst_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int LEN_W = 4
) ();
  logic             req_valid;
  logic             req_ready;
  logic             req_write;
  logic [DEPTH-1:0] req_addr;
  logic [LEN_W-1:0] req_len;
  logic             wr_valid;
  logic             wr_ready;
  logic [WIDTH-1:0] wr_data;
  logic             rd_valid;
  logic             rd_ready;
  logic [WIDTH-1:0] rd_data;

  // Client side: issues requests, supplies write beats, consumes read beats
  modport master (
    output req_valid, req_write, req_addr, req_len, wr_valid, wr_data, rd_ready,
    input  req_ready, wr_ready, rd_valid, rd_data
  );

  // Controller side
  modport slave (
    input  req_valid, req_write, req_addr, req_len, wr_valid, wr_data, rd_ready,
    output req_ready, wr_ready, rd_valid, rd_data
  );
endinterface
`default_nettype wire

// File: rtl/ram_burst_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ram_burst_ctrl
// Purpose  : Burst read/write initiator for a single-port synchronous RAM.
//            Sequences enable/write-enable/address/data beat by beat and
//            returns registered read data under client backpressure.
// Revision : 1.0 - initial release
// ============================================================================
module ram_burst_ctrl #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  ram_burst_ctrl_if.slave  bus,
  output logic             busy,
  output logic             ram_enable,
  output logic             ram_wr_en,
  output logic [DEPTH-1:0] ram_address,
  output logic [WIDTH-1:0] ram_data_in,
  input  logic [WIDTH-1:0] ram_data_out
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WR       = 3'd1,
    S_RD_ISSUE = 3'd2,
    S_RD_CAPT  = 3'd3,
    S_RD_OUT   = 3'd4
  } state_t;

  localparam logic [DEPTH-1:0] ADDR_ONE = DEPTH'(1);
  localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);

  state_t           state_q, state_d;
  logic [DEPTH-1:0] cur_addr_q, cur_addr_d;
  logic [LEN_W-1:0] beats_left_q, beats_left_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;

  logic             req_ready;
  logic             wr_ready;
  logic             ram_en;
  logic             ram_we;
  logic [DEPTH-1:0] ram_addr;

  // Next-state logic plus the combinational RAM pin drive for this cycle
  always_comb begin
    state_d      = state_q;
    cur_addr_d   = cur_addr_q;
    beats_left_d = beats_left_q;
    rd_data_d    = rd_data_q;
    rd_valid_d   = rd_valid_q;
    req_ready    = (state_q == S_IDLE) && !rst;
    wr_ready     = (state_q == S_WR) && !rst;
    ram_en       = 1'b0;
    ram_we       = 1'b0;
    ram_addr     = cur_addr_q;

    case (state_q)
      S_IDLE: begin
        if (bus.req_valid && req_ready) begin
          cur_addr_d   = bus.req_addr;
          beats_left_d = bus.req_len;
          state_d      = bus.req_write ? S_WR : S_RD_ISSUE;
        end
      end
      S_WR: begin
        // wr_valid low is a stall: nothing reaches the RAM
        if (bus.wr_valid) begin
          ram_en     = 1'b1;
          ram_we     = 1'b1;
          cur_addr_d = cur_addr_q + ADDR_ONE;
          if (beats_left_q == '0) begin
            state_d = S_IDLE;
          end else begin
            beats_left_d = beats_left_q - LEN_ONE;
          end
        end
      end
      S_RD_ISSUE: begin
        ram_en  = 1'b1;
        state_d = S_RD_CAPT;
      end
      S_RD_CAPT: begin
        // RAM output is valid one cycle after the issue
        rd_data_d  = ram_data_out;
        rd_valid_d = 1'b1;
        state_d    = S_RD_OUT;
      end
      S_RD_OUT: begin
        if (bus.rd_ready) begin
          rd_valid_d = 1'b0;
          if (beats_left_q == '0) begin
            state_d = S_IDLE;
          end else begin
            // Overlap the next issue with the handshake, at the advanced address
            cur_addr_d   = cur_addr_q + ADDR_ONE;
            beats_left_d = beats_left_q - LEN_ONE;
            ram_en       = 1'b1;
            ram_addr     = cur_addr_d;
            state_d      = S_RD_CAPT;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Keep the RAM quiet while reset is held, whatever state we are in
    if (rst) begin
      ram_en = 1'b0;
      ram_we = 1'b0;
    end
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cur_addr_q   <= '0;
      beats_left_q <= '0;
      rd_data_q    <= '0;
      rd_valid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_addr_q   <= cur_addr_d;
      beats_left_q <= beats_left_d;
      rd_data_q    <= rd_data_d;
      rd_valid_q   <= rd_valid_d;
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.wr_ready  = wr_ready;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_data   = rd_data_q;
  assign busy          = (state_q != S_IDLE);
  assign ram_enable    = ram_en;
  assign ram_wr_en     = ram_we;
  assign ram_address   = ram_addr;
  assign ram_data_in   = bus.wr_data;

endmodule
`default_nettype wire
